init_perm_loader: RTL and testbench
===================================

Name: init_perm_loader

Overview:
Input-side stage of the DES datapath and the counterpart of the final inverse permutation. Accepts 64-bit plaintext blocks over a valid/ready handshake and applies the DES Initial Permutation (IP). Buffers the permuted blocks in a small FIFO and presents L0/R0 halves to the round engine over a second valid/ready handshake. Has no bypass or alternate data path: the output is always a pure function of the accepted block.

Parameters:
DEPTH, 2, FIFO entries; power of two, >= 2
CNT_W, 16, width of accepted-block counter

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous reset, active-low (0 = reset asserted)
flush  input  1  synchronous clear of FIFO contents
in_valid  input  1  plaintext block valid
in_ready  output  1  stage can accept a block
in_data  input  64  plaintext block, bit 63 = DES bit 1
out_valid  output  1  L0/R0 available
out_ready  input  1  round engine consumes L0/R0
out_l  output  32  IP result [63:32]
out_r  output  32  IP result [31:0]
blk_cnt  output  CNT_W  number of blocks accepted since reset

Behaviour:
- IP mapping, combinational on in_data, for k=0..7 and m=0..3:
  - ip[32+8m+(7-k)] = in_data[8k+2m]
  - ip[8m+(7-k)] = in_data[8k+2m+1]
  - Examples: ip[39]=in[0], ip[7]=in[1], ip[32]=in[56]. This is the exact inverse of the final permutation, so FP(IP(x)) = x.
- Reset (rst=0, async): FIFO count=0, read/write pointers=0, all storage=0, blk_cnt=0, out_valid=0, in_ready=0 while rst is low.
- in_ready = (count < DEPTH) and not in reset. in_ready is registered-state only and never depends on out_ready (no ready combinational path).
- Push occurs when in_valid && in_ready at a rising edge. The permuted 64-bit word is written at wr_ptr, and wr_ptr increments mod DEPTH.
- out_valid = (count != 0). out_l/out_r are taken from the entry at rd_ptr. When count==0, out_l/out_r = 0.
- Pop occurs when out_valid && out_ready at a rising edge. rd_ptr increments mod DEPTH.
- Latency: a block accepted at edge N is visible on out_* (out_valid=1) immediately after edge N, with no path from in_data to out_*. Throughput is 1 block/cycle when out_ready is held high.
- Count update: push only → +1; pop only → -1; push and pop together → unchanged. Pointer wrap from DEPTH-1 to 0.
- Full (count==DEPTH): in_ready=0. A pop in that cycle does not enable a push in the same cycle; in_ready rises on the next cycle.
- Empty (count==0): out_ready is ignored and pointers do not move.
- flush=1 at an edge: count, rd_ptr and wr_ptr go to 0, and out_valid drops next cycle. flush overrides a simultaneous push and pop. A block presented that cycle is not accepted and not counted. Storage contents need not be cleared.
- blk_cnt increments by 1 on each accepted push and wraps from 2^CNT_W-1 to 0. It is not affected by flush; it is cleared only by rst.
- in_data/in_valid protocol: the source holds in_data stable while in_valid=1 and in_ready=0. The block does not check this.
- Reset mid-operation: async clear takes effect immediately and all buffered blocks are lost. After rst returns to 1, in_ready rises on the first clock edge.

Test Plan:
- Push 0x0123456789ABCDEF with out_ready=1 → next cycle out_valid=1, out_l=0xCC00CCFF, out_r=0xF0AAF0AA; blk_cnt=1.
- Single-bit walk: in_data=1<<0 → {out_l,out_r} has only bit 39 set; in_data=1<<1 → only bit 7; in_data=1<<56 → only bit 32. Push 0x0 and all-ones → identical outputs.
- Backpressure: out_ready=0, push 3 blocks A,B,C on consecutive cycles → A,B accepted, in_ready=0 on the third, C held. Raise out_ready → order A,B,C with in_ready returning one cycle after the first pop; blk_cnt=3.
- Streaming: in_valid=out_ready=1 for 100 random blocks → 100 outputs in order, each matching the IP model and satisfying FP(output)=input; count never exceeds 1.
- Flush with count=2 and a simultaneous in_valid → next cycle out_valid=0, in_ready=1, blk_cnt unchanged.
- Drop rst to 0 asynchronously mid-stream (between edges) → out_valid, in_ready and blk_cnt go to 0 immediately. After release, the first push yields blk_cnt=1.

Source files
------------

// File: rtl/init_perm_loader.sv
// DES input stage: applies the Initial Permutation to accepted plaintext blocks
// and buffers the L0/R0 halves in a small FIFO ahead of the round engine.
module init_perm_loader #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [63:0]      in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_l,
    output logic [31:0]      out_r,
    output logic [CNT_W-1:0] blk_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL = (PTR_W + 1)'(DEPTH);

    // Handshakes: a transfer happens on a rising edge where valid && ready.
    // in_ready depends only on registered state; out_valid means the FIFO is non-empty.

    logic [PTR_W:0]   count;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [63:0]      mem [DEPTH];
    logic             run;
    logic [63:0]      ip;
    logic             push;
    logic             pop;

    always_comb begin
        ip = '0;
        for (int k = 0; k < 8; k++) begin
            for (int m = 0; m < 4; m++) begin
                ip[32 + 8*m + (7 - k)] = in_data[8*k + 2*m];
                ip[8*m + (7 - k)]      = in_data[8*k + 2*m + 1];
            end
        end
    end

    // run holds in_ready low until the first edge after reset release.
    assign in_ready  = run && (count < FULL);
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready && !flush;
    assign out_l     = out_valid ? mem[rd_ptr][63:32] : 32'h0;
    assign out_r     = out_valid ? mem[rd_ptr][31:0]  : 32'h0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run     <= 1'b0;
            count   <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            blk_cnt <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= 64'h0;
            end
        end else begin
            run <= 1'b1;
            if (push) begin
                mem[wr_ptr] <= ip;
                blk_cnt     <= blk_cnt + 1'b1;
            end
            if (flush) begin
                count  <= '0;
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                if (push && !pop) begin
                    count <= count + 1'b1;
                end else if (pop && !push) begin
                    count <= count - 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_init_perm_loader.sv
// Directed bench for init_perm_loader: DES table reference model, negedge
// scoreboard of accepted blocks, and directed checks of the handshake corners.
module tb_init_perm_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_l;
    logic [31:0] out_r;
    logic [15:0] blk_cnt;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int exp_blk   = 0;

    logic [63:0] exp_q [$];
    logic [63:0] in_q  [$];

    localparam int IP_TAB [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2,
        60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6,
        64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17,  9, 1,
        59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5,
        63, 55, 47, 39, 31, 23, 15, 7
    };

    localparam int FP_TAB [64] = '{
        40, 8, 48, 16, 56, 24, 64, 32,
        39, 7, 47, 15, 55, 23, 63, 31,
        38, 6, 46, 14, 54, 22, 62, 30,
        37, 5, 45, 13, 53, 21, 61, 29,
        36, 4, 44, 12, 52, 20, 60, 28,
        35, 3, 43, 11, 51, 19, 59, 27,
        34, 2, 42, 10, 50, 18, 58, 26,
        33, 1, 41,  9, 49, 17, 57, 25
    };

    init_perm_loader #(.DEPTH(2), .CNT_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_l     (out_l),
        .out_r     (out_r),
        .blk_cnt   (blk_cnt)
    );

    // Clock and reset block
    always #5 clk = ~clk;

    // DES numbering: bit 1 is the MSB, i.e. Verilog bit 64-n.
    function automatic logic [63:0] ip_model(input logic [63:0] d);
        logic [63:0] r;
        for (int i = 1; i <= 64; i++) begin
            r[64 - i] = d[64 - IP_TAB[i - 1]];
        end
        return r;
    endfunction

    function automatic logic [63:0] fp_model(input logic [63:0] d);
        logic [63:0] r;
        for (int i = 1; i <= 64; i++) begin
            r[64 - i] = d[64 - FP_TAB[i - 1]];
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [63:0] d, input logic ordy, input logic fl);
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
    endtask

    task automatic push_peek(input string tag, input logic [63:0] d, input logic [63:0] exp);
        drive(1'b1, d, 1'b0, 1'b0);
        tick();
        exp_blk++;
        drive(1'b0, 64'h0, 1'b0, 1'b0);
        chk(tag, {out_l, out_r}, exp);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    // Scoreboard: inputs are stable at the falling edge, so the transfers seen
    // here are exactly those that the next rising edge performs.
    always @(negedge clk) begin
        if (!rst || flush) begin
            exp_q.delete();
            in_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                chk("sb_nonempty", 64'(exp_q.size() != 0), 64'h1);
                if (exp_q.size() != 0) begin
                    chk("sb_data", {out_l, out_r}, exp_q.pop_front());
                    chk("sb_fp", fp_model({out_l, out_r}), in_q.pop_front());
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(ip_model(in_data));
                in_q.push_back(in_data);
            end
        end
    end

    initial begin
        logic [63:0] a, b, c, d;
        rst = 1'b0;
        drive(1'b0, 64'h0, 1'b0, 1'b0);
        #2;
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_blk_cnt", blk_cnt, 16'd0);
        chk("rst_out_data", {out_l, out_r}, 64'h0);
        #10 rst = 1'b1;
        tick();
        chk("release_in_ready", in_ready, 1'b1);

        // Known-answer block
        drive(1'b1, 64'h0123456789ABCDEF, 1'b1, 1'b0);
        tick();
        exp_blk++;
        drive(1'b0, 64'h0, 1'b1, 1'b0);
        chk("kat_out_valid", out_valid, 1'b1);
        chk("kat_data", {out_l, out_r}, 64'hCC00CCFF_F0AAF0AA);
        chk("kat_blk_cnt", blk_cnt, 16'd1);
        tick();
        chk("kat_drained", out_valid, 1'b0);

        // Single-bit walk and trivial patterns
        push_peek("walk_bit0", 64'h1, 64'h1 << 39);
        push_peek("walk_bit1", 64'h2, 64'h1 << 7);
        push_peek("walk_bit56", 64'h1 << 56, 64'h1 << 32);
        push_peek("zeros", 64'h0, 64'h0);
        push_peek("ones", {64{1'b1}}, {64{1'b1}});
        chk("walk_blk_cnt", blk_cnt, 16'(exp_blk));

        // Backpressure: two entries fill the FIFO, the third block waits
        a = 64'hA5A5_0000_1111_2222;
        b = 64'h3C3C_FFFF_1234_5678;
        c = 64'hDEAD_BEEF_CAFE_F00D;
        drive(1'b1, a, 1'b0, 1'b0);
        tick();
        drive(1'b1, b, 1'b0, 1'b0);
        tick();
        chk("bp_full_in_ready", in_ready, 1'b0);
        drive(1'b1, c, 1'b0, 1'b0);
        tick();
        chk("bp_held_in_ready", in_ready, 1'b0);
        chk("bp_head_a", {out_l, out_r}, ip_model(a));
        out_ready = 1'b1;
        tick();
        chk("bp_ready_after_pop", in_ready, 1'b1);
        chk("bp_head_b", {out_l, out_r}, ip_model(b));
        tick();
        in_valid = 1'b0;
        chk("bp_head_c", {out_l, out_r}, ip_model(c));
        tick();
        exp_blk += 3;
        chk("bp_empty", out_valid, 1'b0);
        chk("bp_blk_cnt", blk_cnt, 16'(exp_blk));

        // Streaming at one block per cycle
        for (int i = 0; i < 100; i++) begin
            drive(1'b1, {$urandom, $urandom}, 1'b1, 1'b0);
            tick();
            exp_blk++;
            chk("stream_in_ready", in_ready, 1'b1);
            chk("stream_out_valid", out_valid, 1'b1);
        end
        drive(1'b0, 64'h0, 1'b1, 1'b0);
        tick();
        chk("stream_drained", out_valid, 1'b0);
        chk("stream_blk_cnt", blk_cnt, 16'(exp_blk));

        // Flush a full FIFO while a new block is offered
        drive(1'b1, 64'h1111_2222_3333_4444, 1'b0, 1'b0);
        tick();
        drive(1'b1, 64'h5555_6666_7777_8888, 1'b0, 1'b0);
        tick();
        exp_blk += 2;
        chk("flush_pre_full", in_ready, 1'b0);
        drive(1'b1, 64'h9999_AAAA_BBBB_CCCC, 1'b1, 1'b1);
        tick();
        drive(1'b0, 64'h0, 1'b0, 1'b0);
        chk("flush_out_valid", out_valid, 1'b0);
        chk("flush_in_ready", in_ready, 1'b1);
        chk("flush_blk_cnt", blk_cnt, 16'(exp_blk));
        chk("flush_out_data", {out_l, out_r}, 64'h0);

        // Asynchronous reset between edges with a block buffered
        d = 64'h0F1E_2D3C_4B5A_6978;
        drive(1'b1, d, 1'b0, 1'b0);
        tick();
        #2 rst = 1'b0;
        #1;
        chk("arst_out_valid", out_valid, 1'b0);
        chk("arst_in_ready", in_ready, 1'b0);
        chk("arst_blk_cnt", blk_cnt, 16'd0);
        drive(1'b0, 64'h0, 1'b0, 1'b0);
        @(negedge clk);
        #1 rst = 1'b1;
        tick();
        chk("arst_release_ready", in_ready, 1'b1);
        drive(1'b1, d, 1'b0, 1'b0);
        tick();
        drive(1'b0, 64'h0, 1'b1, 1'b0);
        chk("arst_first_blk_cnt", blk_cnt, 16'd1);
        chk("arst_first_data", {out_l, out_r}, ip_model(d));
        tick();

        // Bounded drain of any outstanding expectations
        for (int i = 0; i < 20; i++) begin
            if (exp_q.size() == 0) break;
            tick();
        end
        chk("sb_drained", 64'(exp_q.size()), 64'h0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
